// File: rtl/mem_lsu_byte.sv
// Byte-addressable RV32 load/store unit with a private 4-lane data memory and a one-stage WB register.
// Optional `LSU_OOB_CHECK_EN` faults any effective address at or beyond MEM_BYTES; otherwise addresses wrap.

module mem_lsu_lane #(
  parameter int DEPTH = 4096,
  parameter int IW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [IW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata_q <= mem[idx];
  end

  assign rdata = rdata_q;
endmodule

module mem_lsu_byte #(
  parameter int MEM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_imm,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  input  logic        req_reg_write,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_result,
  output logic        wb_misaligned,
  output logic        wb_fault,
  output logic [31:0] wb_addr
);
  localparam int ADDR_WIDTH = $clog2(MEM_BYTES);
  localparam int IW         = ADDR_WIDTH - 2;
  localparam int DEPTH      = MEM_BYTES / 4;

  logic [31:0]   ea;
  logic [1:0]    lane;
  logic [IW-1:0] idx;
  logic          is_ls, is_half, is_word, illegal, oob, misaligned, fault, store_en;
  logic [3:0]    be;
  logic [31:0]   wdata_rep, rdata;

  assign ea   = req_rs1 + req_imm;
  assign lane = ea[1:0];
  assign idx  = ea[ADDR_WIDTH-1:2];

`ifdef LSU_OOB_CHECK_EN
  assign oob = |ea[31:ADDR_WIDTH];
`else
  logic [31-ADDR_WIDTH:0] unused_ea_hi;
  assign unused_ea_hi = ea[31:ADDR_WIDTH];
  assign oob = 1'b0;
`endif

  always_comb begin
    is_ls   = req_load | req_store;
    is_half = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
    is_word = (req_funct3 == 3'b010);
    if (req_load) illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else          illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    misaligned = req_valid & is_ls & ((is_half & ea[0]) | (is_word & (|ea[1:0])));
    fault      = req_valid & is_ls & ((req_load & req_store) | illegal | oob);
    // rst_n gates the write so a store caught by reset never reaches the RAM
    store_en   = rst_n & req_valid & req_store & ~req_load & ~stall & ~flush & ~misaligned & ~fault;
    case (req_funct3[1:0])
      2'b00: begin be = 4'b0001 << lane; wdata_rep = {4{req_wdata[7:0]}};  end
      2'b01: begin be = 4'b0011 << lane; wdata_rep = {2{req_wdata[15:0]}}; end
      default: begin be = 4'b1111;       wdata_rep = req_wdata;            end
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    mem_lsu_lane #(.DEPTH(DEPTH), .IW(IW)) u_lane (
      .clk   (clk),
      .we    (store_en & be[g]),
      .re    (~stall),
      .idx   (idx),
      .wdata (wdata_rep[8*g +: 8]),
      .rdata (rdata[8*g +: 8])
    );
  end

  logic        valid_q, valid_d, rw_q, rw_d, mis_q, mis_d, fault_q, fault_d, ld_q, ld_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;

  always_comb begin
    valid_d = valid_q; rw_d = rw_q; mis_d = mis_q; fault_d = fault_q; ld_d = ld_q;
    rd_d = rd_q; addr_d = addr_q; f3_d = f3_q; lane_d = lane_q;
    if (flush) begin
      valid_d = 1'b0; rw_d = 1'b0; mis_d = 1'b0; fault_d = 1'b0; ld_d = 1'b0;
    end else if (!stall) begin
      valid_d = req_valid;
      rw_d    = req_valid & req_reg_write & ~misaligned & ~fault;
      mis_d   = misaligned;
      fault_d = fault;
      ld_d    = req_valid & req_load & ~req_store & ~misaligned & ~fault;
      rd_d    = req_rd;
      addr_d  = ea;
      f3_d    = req_funct3;
      lane_d  = lane;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0; rw_q <= 1'b0; mis_q <= 1'b0; fault_q <= 1'b0; ld_q <= 1'b0;
      rd_q <= '0; addr_q <= '0; f3_q <= '0; lane_q <= '0;
    end else begin
      valid_q <= valid_d; rw_q <= rw_d; mis_q <= mis_d; fault_q <= fault_d; ld_q <= ld_d;
      rd_q <= rd_d; addr_q <= addr_d; f3_q <= f3_d; lane_q <= lane_d;
    end
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_val;

  always_comb begin
    byte_sel = rdata[8*lane_q +: 8];
    half_sel = lane_q[1] ? rdata[31:16] : rdata[15:0];
    case (f3_q)
      3'b000:  ld_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ld_val = {24'b0, byte_sel};
      3'b001:  ld_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  ld_val = {16'b0, half_sel};
      default: ld_val = rdata;
    endcase
  end

  assign wb_valid      = valid_q;
  assign wb_reg_write  = rw_q;
  assign wb_rd         = rd_q;
  assign wb_misaligned = mis_q;
  assign wb_fault      = fault_q;
  assign wb_addr       = addr_q;
  assign wb_result     = ld_q ? ld_val : 32'b0;
endmodule

// File: tb/tb_mem_lsu_byte.sv
// Directed + randomized bench for mem_lsu_byte against a byte-array memory model.
module tb_mem_lsu_byte;
  localparam int MB = 16384;

  logic clk = 0, rst_n = 0, stall = 0, flush = 0;
  logic req_valid = 0, req_load = 0, req_store = 0, req_reg_write = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_rs1 = 0, req_imm = 0, req_wdata = 0;
  logic [4:0]  req_rd = 0;
  logic        wb_valid, wb_reg_write, wb_misaligned, wb_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result, wb_addr;

  mem_lsu_byte #(.MEM_BYTES(MB)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_rs1(req_rs1), .req_imm(req_imm),
    .req_wdata(req_wdata), .req_rd(req_rd), .req_reg_write(req_reg_write),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result), .wb_misaligned(wb_misaligned), .wb_fault(wb_fault),
    .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  logic [7:0] mdl [MB];
  int nvec = 0, nerr = 0;
  logic        e_valid = 0, e_rw = 0, e_mis = 0, e_fault = 0;
  logic [4:0]  e_rd = 0;
  logic [31:0] e_res = 0, e_addr = 0;
  bit          e_meta = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_wb();
    chk("wb_valid", {31'b0, wb_valid}, {31'b0, e_valid});
    chk("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, e_rw});
    chk("wb_misaligned", {31'b0, wb_misaligned}, {31'b0, e_mis});
    chk("wb_fault", {31'b0, wb_fault}, {31'b0, e_fault});
    chk("wb_result", wb_result, e_res);
    if (e_meta) begin
      chk("wb_rd", {27'b0, wb_rd}, {27'b0, e_rd});
      chk("wb_addr", wb_addr, e_addr);
    end
  endtask

  // One request cycle: drive, model the architectural effect, check WB after the edge.
  task automatic req(input bit v, input bit ld, input bit st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] imm, input logic [31:0] wd,
                     input logic [4:0] rd, input bit rw, input bit stl, input bit fl);
    logic [31:0] ea, val;
    int sz, base;
    bit mis, flt, ill, oob, good;
    req_valid = v; req_load = ld; req_store = st; req_funct3 = f3;
    req_rs1 = a; req_imm = imm; req_wdata = wd; req_rd = rd; req_reg_write = rw;
    stall = stl; flush = fl;
    ea  = a + imm;
    sz  = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
    ill = ld ? !(f3 inside {0, 1, 2, 4, 5}) : !(f3 inside {0, 1, 2});
    oob = 0;
`ifdef LSU_OOB_CHECK_EN
    oob = (ea >= MB);
`endif
    mis  = (v && (ld || st)) && ((sz == 2 && ea % 2 != 0) || (sz == 4 && ea % 4 != 0));
    flt  = (v && (ld || st)) && ((ld && st) || ill || oob);
    base = int'(ea % MB);
    @(posedge clk);
    if (fl) begin
      e_valid = 0; e_rw = 0; e_mis = 0; e_fault = 0; e_res = 0; e_meta = 0;
    end else if (!stl) begin
      val  = 0;
      good = v && ld && !st && !mis && !flt;
      if (good) begin
        for (int i = 0; i < sz; i++) val |= {24'b0, mdl[(base + i) % MB]} << (8 * i);
        if (sz < 4 && f3[2] == 1'b0 && val[8*sz-1]) val |= ~((32'h1 << (8 * sz)) - 1);
      end
      if (v && st && !ld && !mis && !flt)
        for (int i = 0; i < sz; i++) mdl[(base + i) % MB] = wd[8*i +: 8];
      e_valid = v; e_rw = v && rw && !mis && !flt; e_rd = rd; e_addr = ea;
      e_mis = mis; e_fault = flt; e_res = good ? val : 32'b0; e_meta = 1;
    end
    #1 check_wb();
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    req(1, 0, 1, f3, a, 0, d, 5'd0, 0, 0, 0);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a);
    req(1, 1, 0, f3, a, 0, 0, 5'd7, 1, 0, 0);
  endtask

  initial begin
    #12;
    check_wb();
    rst_n = 1;

    sw(32'h100, 32'hDEADBEEF, 3'b010);
    ld(3'b010, 32'h100);
    chk("t1_lw", wb_result, 32'hDEADBEEF);
    chk("t1_rw", {31'b0, wb_reg_write}, 32'd1);

    sw(32'h101, 32'h5A, 3'b000);
    sw(32'h103, 32'h80, 3'b000);
    ld(3'b010, 32'h100); chk("t2_lw", wb_result, 32'h80AD5AEF);
    ld(3'b000, 32'h103); chk("t2_lb", wb_result, 32'hFFFFFF80);
    ld(3'b100, 32'h103); chk("t2_lbu", wb_result, 32'h00000080);

    ld(3'b001, 32'h102); chk("t3_lh", wb_result, 32'hFFFF80AD);
    ld(3'b101, 32'h102); chk("t3_lhu", wb_result, 32'h000080AD);
    sw(32'h100, 32'h1234, 3'b001);
    ld(3'b010, 32'h100); chk("t3_sh_lw", wb_result, 32'h80AD1234);

    ld(3'b010, 32'h102);
    chk("t4_mis", {31'b0, wb_misaligned}, 32'd1);
    chk("t4_addr", wb_addr, 32'h102);
    sw(32'h101, 32'h11111111, 3'b010);
    ld(3'b010, 32'h100); chk("t4_unchanged", wb_result, 32'h80AD1234);

    ld(3'b010, 32'h100);
    for (int i = 0; i < 3; i++) begin
      req(1, 0, 1, 3'b010, 32'h100, 0, 32'h0, 5'd3, 0, 1, 0);
      chk("t5_hold", wb_result, 32'h80AD1234);
    end
    req(1, 0, 1, 3'b010, 32'h100, 0, 32'h0, 5'd0, 0, 0, 1);
    chk("t5_flush_v", {31'b0, wb_valid}, 32'd0);
    ld(3'b010, 32'h100); chk("t5_noflushwr", wb_result, 32'h80AD1234);

    sw(32'h0, 32'h0, 3'b010);
    sw(32'h4000, 32'hCAFE, 3'b010);
`ifdef LSU_OOB_CHECK_EN
    chk("t6_oob_fault", {31'b0, wb_fault}, 32'd1);
    ld(3'b010, 32'h0); chk("t6_lw0", wb_result, 32'h0);
`else
    ld(3'b010, 32'h0); chk("t6_lw0", wb_result, 32'h0000CAFE);
`endif

    // Reset arriving mid-request drops the pending store and clears WB immediately.
    req_valid = 1; req_load = 0; req_store = 1; req_funct3 = 3'b010;
    req_rs1 = 32'h100; req_imm = 0; req_wdata = 32'h55555555; stall = 0; flush = 0;
    #2 rst_n = 0;
    e_valid = 0; e_rw = 0; e_mis = 0; e_fault = 0; e_res = 0; e_rd = 0; e_addr = 0; e_meta = 1;
    #1 check_wb();
    @(posedge clk); #1;
    rst_n = 1; req_valid = 0;
    ld(3'b010, 32'h100); chk("rst_drop", wb_result, 32'h80AD1234);

    for (int i = 0; i < 64; i++) sw(32'h200 + 4 * i, $urandom, 3'b010);

    for (int i = 0; i < 400; i++) begin
      bit v, l, s, rw, stl, fl;
      logic [2:0] f3;
      logic [31:0] tgt, rs1;
      int k;
      v  = ($urandom % 8) != 0;
      k  = $urandom % 16;
      l  = (k < 7) || (k == 15);
      s  = (k >= 7 && k < 13) || (k == 15);
      f3 = ($urandom % 6 == 0) ? 3'($urandom) : 3'($urandom_range(0, 4));
      if (f3 == 3'd3 && ($urandom % 2 == 0)) f3 = 3'd5;
      tgt = 32'h200 + ($urandom % 256);
      if ($urandom % 8 == 0) tgt |= $urandom_range(1, 3) << 14;
      if ($urandom % 32 == 0) tgt |= 32'hFFFF0000;
      rs1 = $urandom;
      rw  = $urandom % 2;
      stl = ($urandom % 8) == 0;
      fl  = ($urandom % 16) == 0;
      req(v, l, s, f3, rs1, tgt - rs1, $urandom, 5'($urandom), rw, stl, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
